// File: rtl/matrix_tx_formatter_pkg.sv
// Shared widths, ASCII constants and byte-selection helpers for the matrix text formatter.
package matrix_tx_formatter_pkg;

    localparam int unsigned ELEMENT_WIDTH   = 8;
    localparam int unsigned BRAM_ADDR_WIDTH = 10;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;

    // Byte idx of one element's text: its digits (MS first), then SP or CR,LF.
    function automatic logic [7:0] element_byte(
        input logic [2:0] idx,
        input logic [3:0] hundreds,
        input logic [3:0] tens,
        input logic [3:0] ones,
        input logic [1:0] count,
        input logic       last_col
    );
        logic [2:0] pos;
        logic [3:0] digit;
        pos   = idx + 3'd3 - {1'b0, count};
        digit = (pos == 3'd0) ? hundreds : ((pos == 3'd1) ? tens : ones);
        element_byte = ASCII_SP;
        if (idx < {1'b0, count}) begin
            element_byte = ASCII_0 + {4'd0, digit};
        end else if (last_col) begin
            element_byte = (idx == {1'b0, count}) ? ASCII_CR : ASCII_LF;
        end
    endfunction

    function automatic logic [2:0] element_len(input logic [1:0] count, input logic last_col);
        return {1'b0, count} + (last_col ? 3'd2 : 3'd1);
    endfunction

endpackage

// File: rtl/matrix_tx_formatter_digits.sv
// Combinational unsigned (<=8-bit) to three BCD digits plus significant-digit count.
module u8_to_dec_digits #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic [1:0]       count
);

    logic [7:0] rem;

    // Compare-subtract: hundreds from 200/100, then up to nine tens.
    always_comb begin
        rem      = 8'(value);
        hundreds = 4'd0;
        tens     = 4'd0;
        if (rem >= 8'd200) begin
            hundreds = 4'd2;
            rem      = rem - 8'd200;
        end else if (rem >= 8'd100) begin
            hundreds = 4'd1;
            rem      = rem - 8'd100;
        end
        for (int i = 0; i < 9; i++) begin
            if (rem >= 8'd10) begin
                rem  = rem - 8'd10;
                tens = tens + 4'd1;
            end
        end
        ones  = rem[3:0];
        count = (hundreds != 4'd0) ? 2'd3 : ((tens != 4'd0) ? 2'd2 : 2'd1);
    end

endmodule

// File: rtl/matrix_tx_formatter.sv
// Streams a stored matrix from BRAM to the UART as row-major ASCII decimal text.
module matrix_tx_formatter
    import matrix_tx_formatter_pkg::*;
#(
    parameter int unsigned ELEMENT_WIDTH = matrix_tx_formatter_pkg::ELEMENT_WIDTH,
    parameter int unsigned ADDR_WIDTH    = matrix_tx_formatter_pkg::BRAM_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [3:0]               dim_m,
    input  logic [3:0]               dim_n,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_RD_REQ, S_RD_WAIT, S_SEND, S_GUARD, S_WAIT_TX, S_NEXT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, rd_addr_d;
    logic [3:0]            dim_m_q, dim_m_d, dim_n_q, dim_n_d;
    logic [3:0]            row_q, row_d, col_q, col_d;
    logic [3:0]            hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic [1:0]            count_q, count_d;
    logic [2:0]            bidx_q, bidx_d;
    logic [3:0]            conv_h, conv_t, conv_o;
    logic [1:0]            conv_n;
    logic [7:0]            next_byte, tx_data_d;
    logic                  rd_en_d, tx_start_d, busy_d, done_d, err_d;
    logic                  last_col, bad_dims;

    u8_to_dec_digits #(.WIDTH(ELEMENT_WIDTH)) u_digits (
        .value    (mem_rd_data),
        .hundreds (conv_h),
        .tens     (conv_t),
        .ones     (conv_o),
        .count    (conv_n)
    );

    assign last_col = (col_q == dim_n_q - 4'd1);
    assign bad_dims = (dim_m_q == 4'd0) || (dim_n_q == 4'd0);

    // First byte of an element comes straight from the converter while its digits are being captured.
    assign next_byte = (state_q == S_RD_WAIT)
                     ? element_byte(3'd0, conv_h, conv_t, conv_o, conv_n, last_col)
                     : element_byte(bidx_q, hund_q, tens_q, ones_q, count_q, last_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            dim_m_q     <= '0;
            dim_n_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            hund_q      <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            count_q     <= '0;
            bidx_q      <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dim_m_q     <= dim_m_d;
            dim_n_q     <= dim_n_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            count_q     <= count_d;
            bidx_q      <= bidx_d;
            mem_rd_en   <= rd_en_d;
            mem_rd_addr <= rd_addr_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dim_m_d = dim_m_q;
        dim_n_d = dim_n_q;
        row_d   = row_q;
        col_d   = col_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        count_d = count_q;
        bidx_d  = bidx_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    dim_m_d = dim_m;
                    dim_n_d = dim_n;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_dims) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                hund_d  = conv_h;
                tens_d  = conv_t;
                ones_d  = conv_o;
                count_d = conv_n;
                bidx_d  = '0;
                state_d = tx_busy ? S_WAIT_TX : S_SEND;
            end
            // The last byte of an element skips S_GUARD: S_NEXT doubles as its guard cycle.
            S_SEND: begin
                bidx_d  = bidx_q + 3'd1;
                state_d = (bidx_q == element_len(count_q, last_col) - 3'd1) ? S_NEXT : S_GUARD;
            end
            S_GUARD: state_d = S_WAIT_TX;
            S_WAIT_TX: begin
                if (!tx_busy) state_d = S_SEND;
            end
            S_NEXT: begin
                if (col_q < dim_n_q - 4'd1) begin
                    col_d   = col_q + 4'd1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_RD_REQ;
                end else if (row_q < dim_m_q - 4'd1) begin
                    col_d   = '0;
                    row_d   = row_q + 4'd1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_RD_REQ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) state_d = S_IDLE;

        // Registered outputs reflect the state being entered.
        rd_en_d    = (state_d == S_RD_REQ);
        rd_addr_d  = rd_en_d ? addr_d : mem_rd_addr;
        tx_start_d = (state_d == S_SEND);
        tx_data_d  = tx_start_d ? next_byte : tx_data;
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = done_d && bad_dims;
    end

endmodule

// File: doc/matrix_tx_formatter.md
# matrix_tx_formatter

Streams one stored matrix from BRAM to the UART transmitter as ASCII decimal text, row by row. It sits directly downstream of the compute and display sub-modes: the controller supplies the base address and dimensions it got from the matrix manager query, then pulses `start`. The block owns the BRAM read port and the UART `tx_start`/`tx_data` pair until it finishes.

## Interface
Parameters:
- `ELEMENT_WIDTH`, default `ELEMENT_WIDTH` from the package (8): element width, unsigned, ≤8.
- `ADDR_WIDTH`, default `BRAM_ADDR_WIDTH` from the package: BRAM address width.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle request, sampled only in IDLE.
- `abort`, in, 1: cancel; driven by the controller when `mode_active` falls.
- `base_addr`, in, ADDR_WIDTH: address of element (0,0); latched on `start`.
- `dim_m`, in, 4: row count; latched on `start`.
- `dim_n`, in, 4: column count; latched on `start`.
- `mem_rd_en`, out, 1: BRAM read strobe.
- `mem_rd_addr`, out, ADDR_WIDTH: BRAM read address.
- `mem_rd_data`, in, ELEMENT_WIDTH: read data, valid 1 cycle after `mem_rd_en`.
- `tx_data`, out, 8: byte to the UART.
- `tx_start`, out, 1: one-cycle send pulse.
- `tx_busy`, in, 1: UART busy.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: qualifies `done`; 1 means bad dimensions.

## Operation
- Output format: row-major. Elements are decimal with no leading zeros ("0" for zero). Elements in a row are separated by 0x20. Each row is terminated by 0x0D 0x0A. No trailing space.
- States and transitions:
  - IDLE: on `start`, latch the inputs and go to CHECK.
  - CHECK: if `dim_m`==0 or `dim_n`==0, go to DONE with `err`=1. Otherwise clear `row`/`col`, set `addr` = `base_addr`, and go to RD_REQ.
  - RD_REQ: assert `mem_rd_en` with `mem_rd_addr` = `addr`, then go to RD_WAIT.
  - RD_WAIT: capture `mem_rd_data`, convert it into a hundreds/tens/ones digit buffer and a digit count (1–3), then go to SEND.
  - SEND: emit the digits most significant first, then either the separator or CR,LF.
  - NEXT: advance the position.
    - If `col`<`dim_n`-1: increment `col`.
    - Else if `row`<`dim_m`-1: set `col`=0 and increment `row`.
    - Else: go to DONE.
    - `addr` increments by 1 on every advance.
  - DONE: pulse `done` (and `err` if set), then return to IDLE.
- Address arithmetic is an ADDR_WIDTH-bit increment and wraps modulo 2^ADDR_WIDTH. The range check is the controller's job.
- `start` while `busy` is ignored. If `start` and `abort` are high in the same cycle in IDLE, `abort` wins and the request is dropped.
- `abort` in any state: return to IDLE on the next edge, clear `tx_start`/`mem_rd_en`, no `done`. A byte already handed to the UART completes on its own.
- Reset mid-operation: all state clears immediately. No `done` is issued.

## Timing
- Reset values: `tx_data`=0x00, `tx_start`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Byte handshake:
  - In a send state with `tx_busy`=0, drive `tx_data` and pulse `tx_start` for exactly 1 cycle.
  - The next cycle is a guard cycle in which `tx_busy` is not sampled, covering the UART's 1-cycle busy latency.
  - `tx_busy` is then waited on before the next byte.
  - `tx_data` is held stable from the pulse until the next pulse.
- Latency from `start` to the first `tx_start` is 4 cycles when `tx_busy` is low: CHECK, RD_REQ, RD_WAIT, SEND.
- Per element, the BRAM read costs 2 cycles before its first byte.
- `done` is asserted 1 cycle after the final LF's guard cycle; `busy` drops in the same cycle as `done`.
- With bad dimensions, `done`+`err` come 2 cycles after `start`, and `tx_start` is never asserted.

## Structure
- `matrix_pkg.vh` gains:
  - ASCII constants: `ASCII_SP`, `ASCII_CR`, `ASCII_LF`, `ASCII_0`.
  - The default widths listed above.
- State encodings stay local to the module.
- One sub-module, `u8_to_dec_digits`: combinational. It converts an unsigned ≤8-bit value into three BCD digits plus a digit count using compare-subtract (≥200, ≥100, then tens). It is instantiated once and registered in RD_WAIT.

## Test plan
- 2x3 matrix {1,2,3; 45,6,255}, UART idle: byte stream "1 2 3\r\n45 6 255\r\n" (17 bytes). `mem_rd_addr` runs base..base+5. One `done` with `err`=0.
- 1x1 matrix {0}: bytes 0x30 0x0D 0x0A. First `tx_start` exactly 4 cycles after `start`.
- `dim_m`=0, `dim_n`=3: `done`=1 and `err`=1 two cycles after `start`. Zero `tx_start` and zero `mem_rd_en` pulses.
- UART holds `tx_busy`=1 for 20 cycles after each byte: no `tx_start` while busy, `tx_data` stable, output stream unchanged.
- `abort` after the third byte of a 3x3 transfer: IDLE the next cycle, `busy`=0, no `done`. A new `start` restarts from (0,0).
- Second `start` pulsed mid-transfer, and `rst_n` pulsed low mid-transfer: the second `start` is ignored. Reset forces all outputs to their reset values within the same cycle.
